// File: rtl/matrix_result_streamer.sv
// Streams the active n x p portion of a 3x3 result matrix, row-major, over valid/ready.
// Dimensions and elements are snapshotted on start so the register file may change freely afterwards.
module matrix_result_streamer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [5:0] n_in,
    input  logic [5:0] p_in,
    input  logic [4:0] c0_in,
    input  logic [4:0] c1_in,
    input  logic [4:0] c2_in,
    input  logic [4:0] c3_in,
    input  logic [4:0] c4_in,
    input  logic [4:0] c5_in,
    input  logic [4:0] c6_in,
    input  logic [4:0] c7_in,
    input  logic [4:0] c8_in,
    output logic [4:0] elem,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic       valid,
    input  logic       ready,
    output logic       last,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] row_q, row_d;
    logic [1:0] col_q, col_d;
    logic [1:0] n_q, n_d;
    logic [1:0] p_q, p_d;
    logic [4:0] snap_q [9];
    logic [4:0] snap_d [9];
    logic [4:0] c_in   [9];

    logic [1:0] n_eff;
    logic [1:0] p_eff;
    logic       xfer;
    logic       col_end;
    logic       row_end;
    logic [3:0] idx;

    assign c_in[0] = c0_in;
    assign c_in[1] = c1_in;
    assign c_in[2] = c2_in;
    assign c_in[3] = c3_in;
    assign c_in[4] = c4_in;
    assign c_in[5] = c5_in;
    assign c_in[6] = c6_in;
    assign c_in[7] = c7_in;
    assign c_in[8] = c8_in;

    // Dimensions larger than the 3x3 storage are clamped, not rejected.
    assign n_eff = (n_in > 6'd3) ? 2'd3 : n_in[1:0];
    assign p_eff = (p_in > 6'd3) ? 2'd3 : p_in[1:0];

    assign valid   = (state_q == STREAM);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign xfer    = valid & ready;
    assign col_end = (col_q == p_q - 2'd1);
    assign row_end = (row_q == n_q - 2'd1);
    assign last    = valid & row_end & col_end;

    assign row  = row_q;
    assign col  = col_q;
    assign idx  = 4'(row_q) * 4'd3 + 4'(col_q);
    assign elem = snap_q[idx];

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        n_d     = n_q;
        p_d     = p_q;
        for (int i = 0; i < 9; i++) begin
            snap_d[i] = snap_q[i];
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d   = n_eff;
                    p_d   = p_eff;
                    row_d = 2'd0;
                    col_d = 2'd0;
                    for (int i = 0; i < 9; i++) begin
                        snap_d[i] = c_in[i];
                    end
                    state_d = (n_eff != 2'd0 && p_eff != 2'd0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (col_end) begin
                        col_d = 2'd0;
                        if (row_end) begin
                            row_d   = 2'd0;
                            state_d = DONE;
                        end else begin
                            row_d = row_q + 2'd1;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            n_q     <= 2'd0;
            p_q     <= 2'd0;
            for (int i = 0; i < 9; i++) begin
                snap_q[i] <= 5'd0;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            n_q     <= n_d;
            p_q     <= p_d;
            for (int i = 0; i < 9; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

endmodule
